// File: rtl/k6502_phase_gen_if.sv
// Phase generator bus: rdy request in, phase levels/strobes/cycle count out.
// Optional sync line exists only when PHASE_SYNC_EN is defined.
interface k6502_phase_gen_if #(
    parameter int CYC_W = 16
);
    logic             rdy;
    logic             ph1;
    logic             ph2;
    logic             ph1_rise;
    logic             ph1_fall;
    logic             ph2_rise;
    logic             ph2_fall;
    logic             stalled;
    logic [CYC_W-1:0] cycle;
`ifdef PHASE_SYNC_EN
    logic             sync;

    modport master (
        input  rdy, sync,
        output ph1, ph2, ph1_rise, ph1_fall,
        output ph2_rise, ph2_fall, stalled, cycle
    );

    modport slave (
        output rdy, sync,
        input  ph1, ph2, ph1_rise, ph1_fall,
        input  ph2_rise, ph2_fall, stalled, cycle
    );
`else
    modport master (
        input  rdy,
        output ph1, ph2, ph1_rise, ph1_fall,
        output ph2_rise, ph2_fall, stalled, cycle
    );

    modport slave (
        output rdy,
        input  ph1, ph2, ph1_rise, ph1_fall,
        input  ph2_rise, ph2_fall, stalled, cycle
    );
`endif
endinterface

// File: rtl/k6502_phase_gen.sv
// Two-phase clock generator: divides ph0 into CYCLE_LEN-tick CPU cycles.
// Optional PHASE_SYNC_EN macro adds a sync input that realigns the phase.
module k6502_phase_gen #(
    parameter int CYCLE_LEN = 12,
    parameter int PH2_START = 6,
    parameter int GAP       = 1,
    parameter int CYC_W     = 16
) (
    input  logic             ph0,
    input  logic             reset,
    k6502_phase_gen_if.master bus
);
    localparam int CW = $clog2(CYCLE_LEN);

    localparam logic [CW-1:0] LAST    = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] P1_END  = CW'(PH2_START - GAP);
    localparam logic [CW-1:0] HOLD_AT = CW'(PH2_START - GAP - 1);
    localparam logic [CW-1:0] P2_BEG  = CW'(PH2_START);
    localparam logic [CW-1:0] P2_END  = CW'(CYCLE_LEN - GAP);

    if (CYCLE_LEN < 4 || GAP < 1 || PH2_START - GAP < 1 ||
        CYCLE_LEN - GAP <= PH2_START) begin : g_bad_params
        $error("k6502_phase_gen: illegal CYCLE_LEN/PH2_START/GAP");
    end

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q;
    logic             sync_req;
    logic             hold;
    logic             ph1_q, ph2_q;
    logic             p1r_q, p1f_q, p2r_q, p2f_q;
    logic             stalled_q;
    logic [CYC_W-1:0] cycle_q;
    logic             ph1_d, ph2_d;
    logic             p1r_d, p1f_d, p2r_d, p2f_d;
    logic             cyc_inc;

    // Next count plus outputs decoded from it, so registered outputs align with cnt
    always_comb begin
        sync_req = 1'b0;
`ifdef PHASE_SYNC_EN
        sync_req = bus.sync;
`endif
        hold = !sync_req && (cnt_q == HOLD_AT) && !bus.rdy;
        if (sync_req)
            cnt_d = '0;
        else if (hold)
            cnt_d = cnt_q;
        else if (cnt_q == LAST)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        ph1_d = cnt_d < P1_END;
        ph2_d = (cnt_d >= P2_BEG) && (cnt_d < P2_END);
        // A held counter never "becomes" anything, so strobes are quiet during stall
        p1r_d = !hold && (cnt_d == '0);
        p1f_d = !hold && (cnt_d == P1_END);
        p2r_d = !hold && (cnt_d == P2_BEG);
        p2f_d = !hold && (cnt_d == P2_END);
        // First wrap out of reset and a sync at cnt 0 do not count a cycle
        cyc_inc = run_q && p1r_d && (cnt_q != '0);
    end

    // Counter, registered outputs and cycle count; async reset
    always_ff @(posedge ph0 or posedge reset) begin
        if (reset) begin
            cnt_q     <= LAST;
            run_q     <= 1'b0;
            ph1_q     <= 1'b0;
            ph2_q     <= 1'b0;
            p1r_q     <= 1'b0;
            p1f_q     <= 1'b0;
            p2r_q     <= 1'b0;
            p2f_q     <= 1'b0;
            stalled_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= 1'b1;
            ph1_q     <= ph1_d;
            ph2_q     <= ph2_d;
            p1r_q     <= p1r_d;
            p1f_q     <= p1f_d;
            p2r_q     <= p2r_d;
            p2f_q     <= p2f_d;
            stalled_q <= hold;
            if (cyc_inc)
                cycle_q <= cycle_q + 1'b1;
        end
    end

    assign bus.ph1      = ph1_q;
    assign bus.ph2      = ph2_q;
    assign bus.ph1_rise = p1r_q;
    assign bus.ph1_fall = p1f_q;
    assign bus.ph2_rise = p2r_q;
    assign bus.ph2_fall = p2f_q;
    assign bus.stalled  = stalled_q;
    assign bus.cycle    = cycle_q;
endmodule

// File: tb/tb_k6502_phase_gen.sv
// Bench for k6502_phase_gen: default instance plus a CYCLE_LEN=16 instance.
// Vector table with scoreboard queue, plus stall/reset/sync sequences.
`timescale 1ns/1ps
module tb_k6502_phase_gen;
    logic ph0 = 1'b0;
    logic reset = 1'b0;

    always #5 ph0 = ~ph0;

    k6502_phase_gen_if #(.CYC_W(16)) m ();
    k6502_phase_gen_if #(.CYC_W(16)) a ();

    k6502_phase_gen dut (
        .ph0   (ph0),
        .reset (reset),
        .bus   (m.master)
    );

    k6502_phase_gen #(
        .CYCLE_LEN (16),
        .PH2_START (8),
        .GAP       (2),
        .CYC_W     (16)
    ) dut_alt (
        .ph0   (ph0),
        .reset (reset),
        .bus   (a.master)
    );

    typedef struct packed {
        logic        ph1;
        logic        ph2;
        logic        p1r;
        logic        p1f;
        logic        p2r;
        logic        p2f;
        logic        st;
        logic [15:0] cyc;
    } out_t;

    typedef struct {
        bit   rdy;
        bit   sy;
        out_t exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   at = -1;
    int   bc = 11;
    int   bcyc = 0;

    function automatic out_t mk(int c, int cyc, bit st, bit strb);
        out_t o;
        o.ph1 = c < 5;
        o.ph2 = (c >= 6) && (c < 11);
        o.p1r = strb && (c == 0);
        o.p1f = strb && (c == 5);
        o.p2r = strb && (c == 6);
        o.p2f = strb && (c == 11);
        o.st  = st;
        o.cyc = 16'(cyc);
        return o;
    endfunction

    function automatic out_t mk_alt(int t);
        out_t o;
        int   c;
        if (t < 0) return '0;
        c = t % 16;
        o.ph1 = c < 6;
        o.ph2 = (c >= 8) && (c < 14);
        o.p1r = c == 0;
        o.p1f = c == 6;
        o.p2r = c == 8;
        o.p2f = c == 14;
        o.st  = 1'b0;
        o.cyc = 16'(t / 16);
        return o;
    endfunction

    function automatic out_t got_m();
        return {m.ph1, m.ph2, m.ph1_rise, m.ph1_fall,
                m.ph2_rise, m.ph2_fall, m.stalled, m.cycle};
    endfunction

    function automatic out_t got_a();
        return {a.ph1, a.ph2, a.ph1_rise, a.ph1_fall,
                a.ph2_rise, a.ph2_fall, a.stalled, a.cycle};
    endfunction

    task automatic check(string name, out_t g, out_t e);
        nvec++;
        if (g !== e) begin
            nerr++;
            $display("FAIL %s: got lvl/strb/st=%b cyc=%0d, exp %b cyc=%0d",
                     name, g[22:16], g.cyc, e[22:16], e.cyc);
        end
        if (g.ph1 && g.ph2) begin
            nerr++;
            $display("FAIL %s_overlap: ph1 and ph2 both high", name);
        end
    endtask

    // Append a vector and remember where the table leaves the counter
    task automatic add(bit rdy, bit sy, int c, int cyc, bit st, bit strb);
        vec_t v;
        v.rdy = rdy;
        v.sy  = sy;
        v.exp = mk(c, cyc, st, strb);
        vecs.push_back(v);
        bc   = c;
        bcyc = cyc;
    endtask

    task automatic adv(int n);
        for (int i = 0; i < n; i++) begin
            int nc;
            nc = (bc + 1) % 12;
            add(1'b1, 1'b0, nc, (nc == 0) ? bcyc + 1 : bcyc, 1'b0, 1'b1);
        end
    endtask

    task automatic step(bit rdy, bit sy, out_t e, string name);
        m.rdy = rdy;
`ifdef PHASE_SYNC_EN
        m.sync = sy;
`endif
        sb.push_back(e);
        @(posedge ph0);
        #1;
        at++;
        check(name, got_m(), sb.pop_front());
        check({name, "_alt"}, got_a(), mk_alt(at));
    endtask

    initial begin
        m.rdy = 1'b1;
        a.rdy = 1'b1;
`ifdef PHASE_SYNC_EN
        m.sync = 1'b0;
        a.sync = 1'b0;
`endif
        // free run, then rdy pulses at cnt 2 and 8 that must be ignored
        for (int t = 0; t < 48; t++) begin
            int pc;
            pc = (t + 11) % 12;
            add(!(t >= 24 && (pc == 2 || pc == 8)), 1'b0,
                t % 12, t / 12, 1'b0, 1'b1);
        end
        // stall three ticks on the last ph1 tick, then release
        adv(5);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4, bcyc, 1'b1, 1'b0);
        add(1'b1, 1'b0, 5, bcyc, 1'b0, 1'b1);
        adv(16);
`ifdef PHASE_SYNC_EN
        add(1'b1, 1'b1, 0, bcyc + 1, 1'b0, 1'b1);
        add(1'b1, 1'b1, 0, bcyc, 1'b0, 1'b1);
        adv(4);
        add(1'b0, 1'b0, 4, bcyc, 1'b1, 1'b0);
        add(1'b0, 1'b1, 0, bcyc + 1, 1'b0, 1'b1);
        adv(3);
`endif

        #1 reset = 1'b1;
        #1 check("reset_async", got_m(), '0);
        check("reset_async_alt", got_a(), '0);
        repeat (2) @(posedge ph0);
        #1 check("reset_held", got_m(), '0);
        reset = 1'b0;

        foreach (vecs[i])
            step(vecs[i].rdy, vecs[i].sy, vecs[i].exp, $sformatf("vec%0d", i));

        // reset asserted mid-ph2 at cnt 7
        while (bc != 7) begin
            int nc;
            nc = (bc + 1) % 12;
            if (nc == 0) bcyc++;
            bc = nc;
            step(1'b1, 1'b0, mk(bc, bcyc, 1'b0, 1'b1), "to_cnt7");
        end
        #2 reset = 1'b1;
        #1 check("mid_reset", got_m(), '0);
        at = -1;
        check("mid_reset_alt", got_a(), '0);
        @(posedge ph0);
        #1 check("mid_reset_edge", got_m(), '0);
        reset = 1'b0;
        for (int t = 0; t <= 13; t++)
            step(1'b1, 1'b0, mk(t % 12, t / 12, 1'b0, 1'b1),
                 $sformatf("post_reset%0d", t));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
